// File: rtl/ifm_pingpong_buffer_pkg.sv
`default_nettype none
// ============================================================================
// ifm_pingpong_buffer_pkg : shared defaults and state types for the IFM buffer
// Revision: 1.0
// ============================================================================
package ifm_pingpong_buffer_pkg;

    localparam int IFM_LANES = 9;
    localparam int IFM_DEPTH = 96;

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_FLUSH = 2'd2
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/ifm_pingpong_buffer_sram_bank.sv
`default_nettype none
// ============================================================================
// ifm_sram_bank : one IFM bank, per-lane active-low write enable, 1-cycle read
// Revision: 1.0
// ============================================================================
module ifm_sram_bank #(
    parameter int LANES  = 9,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = 96,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                CK,
    input  logic                CS,
    input  logic                OE,
    input  logic [LANES-1:0]    WEB,
    input  logic [ADDR_W-1:0]   A,
    input  logic [BYTE_W-1:0]   D [LANES],
    output logic [BYTE_W-1:0]   Q [LANES]
);

    // Behavioural stand-in with the same pin behaviour as the foundry macro.
    logic [BYTE_W-1:0] mem [LANES][DEPTH];

    always_ff @(posedge CK) begin
        if (CS) begin
            for (int i = 0; i < LANES; i++) begin
                if (!WEB[i]) begin
                    mem[i][A] <= D[i];
                end
                if (OE) begin
                    Q[i] <= mem[i][A];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifm_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// ifm_pingpong_buffer : double-banked IFM buffer, valid/ready fill, skewed drain
// Revision: 1.0
// ============================================================================
module ifm_pingpong_buffer
    import ifm_pingpong_buffer_pkg::*;
#(
    parameter int LANES  = IFM_LANES,
    parameter int BYTE_W = 8,
    parameter int DEPTH  = IFM_DEPTH
) (
    input  logic                CK,
    input  logic                RSTn,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [BYTE_W-1:0]   wr_data [LANES],
    input  logic [LANES-1:0]    wr_mask,
    input  logic                wr_last,
    input  logic                rd_start,
    output logic                rd_busy,
    output logic [BYTE_W-1:0]   rd_data [LANES],
    output logic [LANES-1:0]    rd_lane_valid,
    output logic                rd_done,
    output logic [1:0]          bank_full
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int LEN_W   = ADDR_W + 1;
    localparam int FLUSH_W = (LANES > 1) ? $clog2(LANES) : 1;

    bank_state_e         bstate_q [2];
    bank_state_e         bstate_d [2];
    logic [LEN_W-1:0]    len_q [2];
    logic [LEN_W-1:0]    len_d [2];
    logic                wbank_q, wbank_d;
    logic                rbank_q, rbank_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    rd_state_e           rstate_q, rstate_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic                rd_issue_q, rd_issue_d;

    logic                wr_fire;
    logic                rd_read;

    assign wr_ready  = (bstate_q[wbank_q] == B_EMPTY) || (bstate_q[wbank_q] == B_FILLING);
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_read   = (rstate_q == R_READ);
    assign rd_busy   = (rstate_q != R_IDLE);
    assign rd_done   = (rstate_q == R_FLUSH) && (flush_q == FLUSH_W'(LANES - 1));
    assign bank_full = {(bstate_q[1] == B_FULL), (bstate_q[0] == B_FULL)};

    always_comb begin
        bstate_d   = bstate_q;
        len_d      = len_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        wr_addr_d  = wr_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rstate_d   = rstate_q;
        flush_d    = flush_q;
        rd_issue_d = rd_read;

        if (wr_fire) begin
            bstate_d[wbank_q] = B_FILLING;
            wr_addr_d         = wr_addr_q + ADDR_W'(1);
            if (wr_last || (wr_addr_q == ADDR_W'(DEPTH - 1))) begin
                len_d[wbank_q]    = LEN_W'(wr_addr_q) + LEN_W'(1);
                bstate_d[wbank_q] = B_FULL;
                wr_addr_d         = '0;
                wbank_d           = ~wbank_q;
            end
        end

        // Write and read sides only ever touch opposite banks' state.
        unique case (rstate_q)
            R_IDLE: begin
                if (rd_start && (bstate_q[rbank_q] == B_FULL)) begin
                    bstate_d[rbank_q] = B_DRAINING;
                    rd_cnt_d          = '0;
                    rstate_d          = R_READ;
                end
            end
            R_READ: begin
                if (LEN_W'(rd_cnt_q) == (len_q[rbank_q] - LEN_W'(1))) begin
                    rstate_d = R_FLUSH;
                    flush_d  = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                end
            end
            R_FLUSH: begin
                if (rd_done) begin
                    bstate_d[rbank_q] = B_EMPTY;
                    rbank_d           = ~rbank_q;
                    rstate_d          = R_IDLE;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            bstate_q   <= '{B_EMPTY, B_EMPTY};
            len_q      <= '{default: '0};
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            wr_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rstate_q   <= R_IDLE;
            flush_q    <= '0;
            rd_issue_q <= 1'b0;
        end else begin
            bstate_q   <= bstate_d;
            len_q      <= len_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            wr_addr_q  <= wr_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rstate_q   <= rstate_d;
            flush_q    <= flush_d;
            rd_issue_q <= rd_issue_d;
        end
    end

    logic                cs0, cs1, rd0, rd1;
    logic [LANES-1:0]    web0, web1;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [BYTE_W-1:0]   q0 [LANES];
    logic [BYTE_W-1:0]   q1 [LANES];
    logic [BYTE_W-1:0]   q_sel [LANES];

    assign rd0   = rd_read && !rbank_q;
    assign rd1   = rd_read &&  rbank_q;
    assign cs0   = (wr_fire && !wbank_q) || rd0;
    assign cs1   = (wr_fire &&  wbank_q) || rd1;
    assign web0  = (wr_fire && !wbank_q) ? ~wr_mask : '1;
    assign web1  = (wr_fire &&  wbank_q) ? ~wr_mask : '1;
    assign addr0 = rd0 ? rd_cnt_q : wr_addr_q;
    assign addr1 = rd1 ? rd_cnt_q : wr_addr_q;

    ifm_sram_bank #(.LANES(LANES), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) u_bank0 (
        .CK(CK), .CS(cs0), .OE(rd0), .WEB(web0), .A(addr0), .D(wr_data), .Q(q0)
    );

    ifm_sram_bank #(.LANES(LANES), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) u_bank1 (
        .CK(CK), .CS(cs1), .OE(rd1), .WEB(web1), .A(addr1), .D(wr_data), .Q(q1)
    );

    // rbank is stable from the first read until after the last lane drains.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            q_sel[i] = rbank_q ? q1[i] : q0[i];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign rd_lane_valid[0] = rd_issue_q;
            assign rd_data[0]       = rd_issue_q ? q_sel[0] : '0;
        end else begin : g_skew
            logic [BYTE_W-1:0] dat_q [i];
            logic [BYTE_W-1:0] dat_d [i];
            logic [i-1:0]      vld_q, vld_d;

            always_comb begin
                dat_d[0] = q_sel[i];
                vld_d[0] = rd_issue_q;
                for (int k = 1; k < i; k++) begin
                    dat_d[k] = dat_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end

            always_ff @(posedge CK or negedge RSTn) begin
                if (!RSTn) begin
                    dat_q <= '{default: '0};
                    vld_q <= '0;
                end else begin
                    dat_q <= dat_d;
                    vld_q <= vld_d;
                end
            end

            assign rd_lane_valid[i] = vld_q[i-1];
            assign rd_data[i]       = vld_q[i-1] ? dat_q[i-1] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifm_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// tb_ifm_pingpong_buffer : directed + random fills/drains against a cycle model
// Revision: 1.0
// ============================================================================
module tb_ifm_pingpong_buffer;

    localparam int LANES  = 9;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 96;

    logic               CK = 1'b0;
    logic               RSTn = 1'b0;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [BYTE_W-1:0]  wr_data [LANES];
    logic [LANES-1:0]   wr_mask = '1;
    logic               wr_last = 1'b0;
    logic               rd_start = 1'b0;
    logic               rd_busy;
    logic [BYTE_W-1:0]  rd_data [LANES];
    logic [LANES-1:0]   rd_lane_valid;
    logic               rd_done;
    logic [1:0]         bank_full;

    always #5 CK = ~CK;

    ifm_pingpong_buffer #(.LANES(LANES), .BYTE_W(BYTE_W), .DEPTH(DEPTH)) dut (
        .CK(CK), .RSTn(RSTn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_mask(wr_mask), .wr_last(wr_last),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_data(rd_data),
        .rd_lane_valid(rd_lane_valid), .rd_done(rd_done), .bank_full(bank_full)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: bank contents, ownership flags and the active drain window.
    logic [7:0] m_mem [2][DEPTH][LANES];
    bit  m_full [2];
    bit  m_drain [2];
    int  m_len [2];
    int  m_wbank, m_rbank, m_waddr;
    bit  m_act, m_acc;
    int  m_T, m_L, m_bank;

    int  obs_v8_first, obs_done, obs_ready_first, obs_stall;
    bit  track_ready;
    int  guard;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full  = '{0, 0};
        m_drain = '{0, 0};
        m_wbank = 0;
        m_rbank = 0;
        m_waddr = 0;
        m_act   = 0;
    endtask

    task automatic check_outputs();
        logic [LANES*8-1:0] exp_d, obs_d;
        logic [LANES-1:0]   exp_v;
        bit                 e_busy, e_done;
        exp_d = '0;
        exp_v = '0;
        for (int i = 0; i < LANES; i++) begin
            obs_d[i*8 +: 8] = rd_data[i];
            if (m_act && cyc >= m_T + 2 + i && cyc <= m_T + m_L + 1 + i) begin
                exp_v[i]        = 1'b1;
                exp_d[i*8 +: 8] = m_mem[m_bank][cyc - m_T - 2 - i][i];
            end
        end
        e_busy = m_act && cyc >= m_T + 1 && cyc <= m_T + m_L + LANES;
        e_done = m_act && cyc == m_T + m_L + LANES;
        if (rd_lane_valid[LANES-1] && obs_v8_first < 0) obs_v8_first = cyc;
        if (rd_done && obs_done < 0) obs_done = cyc;
        if (track_ready && wr_ready && obs_ready_first < 0) obs_ready_first = cyc;
        if (wr_valid && !wr_ready) obs_stall++;
        chk("lane_valid", 128'(rd_lane_valid), 128'(exp_v));
        chk("rd_data", 128'(obs_d), 128'(exp_d));
        chk("rd_busy", 128'(rd_busy), 128'(e_busy));
        chk("rd_done", 128'(rd_done), 128'(e_done));
        chk("wr_ready", 128'(wr_ready), 128'(!m_full[m_wbank] && !m_drain[m_wbank]));
        chk("bank_full", 128'(bank_full), 128'({m_full[1], m_full[0]}));
    endtask

    task automatic model_edge();
        bit done, start, acc;
        if (!RSTn) begin
            model_reset();
            m_acc = 0;
            return;
        end
        done  = m_act && cyc == m_T + m_L + LANES;
        start = !m_act && rd_start && m_full[m_rbank];
        acc   = wr_valid && !m_full[m_wbank] && !m_drain[m_wbank];
        m_acc = acc;
        if (acc) begin
            for (int i = 0; i < LANES; i++)
                if (wr_mask[i]) m_mem[m_wbank][m_waddr][i] = wr_data[i];
            if (wr_last || m_waddr == DEPTH - 1) begin
                m_full[m_wbank] = 1;
                m_len[m_wbank]  = m_waddr + 1;
                m_waddr         = 0;
                m_wbank         = 1 - m_wbank;
            end else begin
                m_waddr++;
            end
        end
        if (done) begin
            m_drain[m_bank] = 0;
            m_act           = 0;
            m_rbank         = 1 - m_rbank;
        end
        if (start) begin
            m_act            = 1;
            m_T              = cyc;
            m_L              = m_len[m_rbank];
            m_bank           = m_rbank;
            m_full[m_rbank]  = 0;
            m_drain[m_rbank] = 1;
        end
    endtask

    task automatic step();
        check_outputs();
        model_edge();
        @(negedge CK);
        cyc++;
    endtask

    task automatic fill(input int n, input bit ramp, input bit last_end,
                        input int mword, input logic [LANES-1:0] mval, input bit rmask);
        for (int w = 0; w < n; w++) begin
            for (int i = 0; i < LANES; i++) wr_data[i] = ramp ? 8'(w + i) : 8'($urandom);
            wr_mask  = rmask ? LANES'($urandom) : ((w == mword) ? mval : '1);
            wr_last  = last_end && (w == n - 1);
            wr_valid = 1'b1;
            m_acc    = 0;
            guard    = 0;
            while (!m_acc && guard < 400) begin
                step();
                guard++;
            end
            chk("fill_timeout", 128'(m_acc), 128'(1));
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_mask  = '1;
    endtask

    task automatic start_drain();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic drain_wait();
        guard = 0;
        while (m_act && guard < 400) begin
            step();
            guard++;
        end
        chk("drain_timeout", 128'(m_act), 128'(0));
    endtask

    task automatic reset_pulse();
        RSTn = 1'b0;
        #1;
        model_reset();
        step();
        step();
        RSTn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LANES; i++) wr_data[i] = '0;
        obs_v8_first = -1; obs_done = -1; obs_ready_first = -1; obs_stall = 0;
        track_ready = 0;
        model_reset();
        @(negedge CK);
        step();
        chk("reset_ready", 128'(wr_ready), 128'(1));
        chk("reset_valid", 128'(rd_lane_valid), 128'(0));
        RSTn = 1'b1;
        step();

        // Full-depth ramp fill of bank0, then drain.
        fill(DEPTH, 1, 0, -1, '0, 0);
        chk("t1_bank_full", 128'(bank_full), 128'(2'b01));
        obs_v8_first = -1; obs_done = -1;
        start_drain();
        drain_wait();
        chk("t1_lane8_first", 128'(obs_v8_first - m_T), 128'(10));
        chk("t1_done_cycle", 128'(obs_done - m_T), 128'(105));

        // Short fill with a masked word; masked lanes keep the ramp values.
        reset_pulse();
        fill(5, 0, 1, 2, 9'h1F0, 0);
        chk("t2_full", 128'(bank_full), 128'(2'b01));
        obs_done = -1;
        start_drain();
        drain_wait();
        chk("t2_done_cycle", 128'(obs_done - m_T), 128'(14));

        // Both banks full; third fill blocks until bank0 is released.
        reset_pulse();
        fill(DEPTH, 0, 0, -1, '0, 0);
        fill(DEPTH, 0, 0, -1, '0, 0);
        chk("t3_blocked", 128'(wr_ready), 128'(0));
        chk("t3_both_full", 128'(bank_full), 128'(2'b11));
        start_drain();
        obs_ready_first = -1;
        track_ready = 1;
        fill(DEPTH, 0, 0, -1, '0, 0);
        track_ready = 0;
        chk("t3_release", 128'(obs_ready_first - m_T), 128'(106));

        // Drain bank1, then drain bank0 while refilling bank1 at full rate.
        start_drain();
        drain_wait();
        rd_start = 1'b1;
        obs_stall = 0;
        obs_done = -1;
        fill(DEPTH, 0, 0, -1, '0, 1);
        chk("t4_no_stall", 128'(obs_stall), 128'(0));
        guard = 0;
        while (!(m_act && m_bank == 1) && guard < 200) begin
            step();
            guard++;
        end
        rd_start = 1'b0;
        chk("t4_b2b_start", 128'(m_T - obs_done), 128'(1));
        drain_wait();

        // rd_start with nothing full, and while busy.
        rd_start = 1'b1;
        repeat (3) step();
        rd_start = 1'b0;
        chk("t5_idle", 128'(rd_busy), 128'(0));
        fill(10, 0, 1, -1, '0, 0);
        fill(7, 0, 1, -1, '0, 0);
        start_drain();
        rd_start = 1'b1;
        repeat (5) step();
        rd_start = 1'b0;
        chk("t5_busy_full", 128'(bank_full), 128'(2'b10));
        drain_wait();
        start_drain();
        drain_wait();

        // Reset in the middle of a drain.
        fill(30, 0, 1, -1, '0, 0);
        start_drain();
        while (cyc < m_T + 20) step();
        obs_done = -1;
        RSTn = 1'b0;
        #1;
        chk("t6_valid", 128'(rd_lane_valid), 128'(0));
        chk("t6_full", 128'(bank_full), 128'(0));
        chk("t6_ready", 128'(wr_ready), 128'(1));
        chk("t6_busy", 128'(rd_busy), 128'(0));
        model_reset();
        step();
        step();
        RSTn = 1'b1;
        repeat (20) step();
        chk("t6_no_done", 128'(obs_done >= 0), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
